// File: rtl/controlador_memoria_dados.sv
// controlador_memoria_dados
//   Load/store sequencer placed in front of a 64-bit, word-addressed data memory.
//   The memory has an asynchronous read and a synchronous write. One request is
//   served at a time. Requests are byte-addressed, little-endian, and sized B/H/W/D.
//   Misaligned requests complete with an error and never touch memory.
//   Loads extract the addressed field and then sign- or zero-extend it.
//   Sub-doubleword stores read the whole word, merge the new bytes in, and write it back.
//
// Ports
//   clk, reset      clock; synchronous active-high reset
//   req_valid       request handshake; req_ready is high only in IDLE
//   req_ready
//   req_we          1 = store, 0 = load
//   req_addr        byte address
//   req_size        0=B 1=H 2=W 3=D
//   req_unsigned    zero-extend loads when 1
//   req_wdata       store data, right-justified
//   rsp_valid       one-cycle completion pulse
//   rsp_err         misalignment flag; held until the next completion
//   rsp_rdata       load result; held until the next completion
//   mem_addr        word address
//   mem_we          memory write enable
//   mem_din         memory write data
//   mem_dout        memory read data (async)
module controlador_memoria_dados #(
  parameter int BITS      = 64,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [BITS-1:0]      req_wdata,
  output logic                 rsp_valid,
  output logic                 rsp_err,
  output logic [BITS-1:0]      rsp_rdata,
  output logic [ADDR_BITS-4:0] mem_addr,
  output logic                 mem_we,
  output logic [BITS-1:0]      mem_din,
  input  logic [BITS-1:0]      mem_dout
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  state_t state, state_nxt;

  logic [ADDR_BITS-1:0] addr_q;
  logic [1:0]           size_q;
  logic                 we_q;
  logic                 uns_q;
  logic [BITS-1:0]      wdata_q;
  logic [BITS-1:0]      rdbuf;
  logic                 accept;

  // A field of 2^size bytes must start on a multiple of its own size.
  function automatic logic misaligned(input logic [2:0] off, input logic [1:0] size);
    logic res;
    case (size)
      2'd0:    res = 1'b0;
      2'd1:    res = off[0];
      2'd2:    res = |off[1:0];
      default: res = |off;
    endcase
    return res;
  endfunction

  // Move lane 'off' down to lane 0, then extend from the top bit of the field.
  function automatic logic [BITS-1:0] extract(input logic [BITS-1:0] dout,
                                              input logic [2:0]      off,
                                              input logic [1:0]      size,
                                              input logic            uns);
    logic [BITS-1:0] sh;
    logic [BITS-1:0] res;
    sh = dout >> {off, 3'b000};
    case (size)
      2'd0:    res = {{56{~uns & sh[7]}},  sh[7:0]};
      2'd1:    res = {{48{~uns & sh[15]}}, sh[15:0]};
      2'd2:    res = {{32{~uns & sh[31]}}, sh[31:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  // Replace lanes off .. off+2^size-1 of 'old' with the low bytes of 'wdata'.
  function automatic logic [BITS-1:0] merge_lanes(input logic [BITS-1:0] old,
                                                  input logic [BITS-1:0] wdata,
                                                  input logic [2:0]      off,
                                                  input logic [1:0]      size);
    logic [BITS-1:0] res;
    int              j;
    int              nb;
    res = old;
    nb  = 1 << size;
    for (int k = 0; k < 8; k++) begin
      j = k - int'(off);
      if (j >= 0 && j < nb) res[8*k +: 8] = wdata[8*j +: 8];
    end
    return res;
  endfunction

  assign accept = req_valid & req_ready;

  always_comb begin
    state_nxt = state;
    req_ready = (state == IDLE);
    rsp_valid = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_q[ADDR_BITS-1:3];
    mem_din   = wdata_q;
    case (state)
      IDLE: begin
        if (req_valid)
          state_nxt = misaligned(req_addr[2:0], req_size) ? RESP : ACCESS;
      end
      ACCESS: begin
        if (we_q && size_q != 2'd3) begin
          state_nxt = WRITE;
        end else begin
          mem_we    = we_q;
          state_nxt = RESP;
        end
      end
      WRITE: begin
        mem_we    = 1'b1;
        mem_din   = merge_lanes(rdbuf, wdata_q, addr_q[2:0], size_q);
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Nothing may reach memory or the requester while reset is asserted.
    if (reset) begin
      mem_we    = 1'b0;
      rsp_valid = 1'b0;
    end
  end

  // Control state and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (accept && misaligned(req_addr[2:0], req_size)) begin
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end else if (state == ACCESS) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= we_q ? '0 : extract(mem_dout, addr_q[2:0], size_q, uns_q);
      end
    end
  end

  // Request capture and read buffer (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= req_addr;
      size_q  <= req_size;
      we_q    <= req_we;
      uns_q   <= req_unsigned;
      wdata_q <= req_wdata;
    end
    if (state == ACCESS) rdbuf <= mem_dout;
  end

endmodule

// File: tb/tb_controlador_memoria_dados.sv
module tb_controlador_memoria_dados;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [63:0] rsp_rdata;
  logic [4:0]  mem_addr;
  logic        mem_we;
  logic [63:0] mem_din;
  logic [63:0] mem_dout;

  controlador_memoria_dados #(.BITS(64), .ADDR_BITS(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Data memory: async read, sync write
  logic [63:0] mem [32];
  assign mem_dout = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_din;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [63:0] rdata;
    int          cyc;
  } exp_t;
  exp_t sbq[$];

  int vectors    = 0;
  int miscompares = 0;
  int we_cnt     = 0;
  int last_we_cyc = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  // Monitor: pop expected response whenever the DUT completes
  always @(negedge clk) begin
    if (mem_we) begin
      we_cnt++;
      last_we_cyc = cyc;
    end
    if (rsp_valid) begin
      if (sbq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Called at a negedge; leaves req_valid high and returns at the negedge after accept.
  task automatic issue(input logic we, input logic [7:0] addr, input logic [1:0] size,
                       input logic uns, input logic [63:0] wdata,
                       input logic exp_err, input logic [63:0] exp_rdata,
                       input int lat, input bit push, output int acc);
    int n;
    exp_t e;
    req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wdata;
    req_valid = 1'b1;
    n = 0;
    acc = -1;
    while (!req_ready && n < 20) begin
      @(posedge clk); @(negedge clk); n++;
    end
    if (!req_ready) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout: got req_ready=0 for 20 cycles expected 1");
    end else begin
      acc = cyc;
      if (push) begin
        e.err = exp_err; e.rdata = exp_rdata; e.cyc = cyc + lat;
        sbq.push_back(e);
      end
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sbq.size() != 0 || !req_ready) && n < 30) begin
      @(posedge clk); @(negedge clk); n++;
    end
    if (sbq.size() != 0 || !req_ready) begin
      vectors++; miscompares++;
      $display("FAIL idle_timeout: got %0d pending responses expected 0", sbq.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, w0;
    int acc [4];
    for (int i = 0; i < 32; i++) mem[i] = 64'd0;
    mem[0] = 64'd51;
    mem[1] = 64'd94;
    mem[3] = 64'hFFFF_FFFF_FFFF_4868;   // -47000
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 8'd0;
    req_size = 2'd0; req_unsigned = 1'b0; req_wdata = 64'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", {63'd0, req_ready}, 64'd1);
    check("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("reset_rsp_err", {63'd0, rsp_err}, 64'd0);
    check("reset_rsp_rdata", rsp_rdata, 64'd0);
    check("reset_mem_we", {63'd0, mem_we}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Loads from word3
    issue(0, 8'h18, 2'd3, 0, 64'd0, 0, 64'hFFFF_FFFF_FFFF_4868, 2, 1, a); req_valid = 0;
    wait_idle();
    issue(0, 8'h1A, 2'd0, 0, 64'd0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 1, a); req_valid = 0;
    wait_idle();
    issue(0, 8'h1A, 2'd0, 1, 64'd0, 0, 64'h0000_0000_0000_00FF, 2, 1, a); req_valid = 0;
    wait_idle();
    issue(0, 8'h19, 2'd0, 0, 64'd0, 0, 64'h0000_0000_0000_0048, 2, 1, a); req_valid = 0;
    wait_idle();

    // Store H into word1 via read-modify-write
    w0 = we_cnt;
    issue(1, 8'h0A, 2'd1, 0, 64'h0000_0000_0000_ABCD, 0, 64'd0, 3, 1, a); req_valid = 0;
    wait_idle();
    check("storeh_we_count", 64'(we_cnt - w0), 64'd1);
    check("storeh_we_cycle", 64'(last_we_cyc), 64'(a + 2));
    check("storeh_mem1", mem[1], 64'h0000_0000_ABCD_005E);
    issue(0, 8'h08, 2'd3, 0, 64'd0, 0, 64'h0000_0000_ABCD_005E, 2, 1, a); req_valid = 0;
    wait_idle();

    // Misaligned requests
    w0 = we_cnt;
    issue(0, 8'h0E, 2'd2, 0, 64'd0, 1, 64'd0, 1, 1, a); req_valid = 0;
    wait_idle();
    issue(1, 8'h04, 2'd3, 0, 64'hDEAD_BEEF_CAFE_F00D, 1, 64'd0, 1, 1, a); req_valid = 0;
    wait_idle();
    check("misalign_we_count", 64'(we_cnt - w0), 64'd0);
    check("misalign_mem0", mem[0], 64'd51);
    check("misalign_mem1", mem[1], 64'h0000_0000_ABCD_005E);

    // Store D then read it back
    issue(1, 8'h20, 2'd3, 0, 64'h0123_4567_89AB_CDEF, 0, 64'd0, 2, 1, a); req_valid = 0;
    wait_idle();
    check("stored_mem4", mem[4], 64'h0123_4567_89AB_CDEF);

    // Reset during the WRITE cycle of a sub-D store
    w0 = we_cnt;
    issue(1, 8'h00, 2'd2, 0, 64'h0000_0000_1234_5678, 0, 64'd0, 3, 0, a); req_valid = 0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("rst_write_mem_we", {63'd0, mem_we}, 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rst_write_mem0", mem[0], 64'd51);
    check("rst_write_we_count", 64'(we_cnt - w0), 64'd0);
    check("rst_write_ready", {63'd0, req_ready}, 64'd1);
    issue(0, 8'h00, 2'd3, 0, 64'd0, 0, 64'd51, 2, 1, a); req_valid = 0;
    wait_idle();

    // Back-to-back loads with req_valid held high
    issue(0, 8'h18, 2'd1, 0, 64'd0, 0, 64'h0000_0000_0000_4868, 2, 1, acc[0]);
    issue(0, 8'h1E, 2'd1, 0, 64'd0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 1, acc[1]);
    issue(0, 8'h1C, 2'd2, 1, 64'd0, 0, 64'h0000_0000_FFFF_FFFF, 2, 1, acc[2]);
    issue(0, 8'h08, 2'd0, 0, 64'd0, 0, 64'h0000_0000_0000_005E, 2, 1, acc[3]);
    req_valid = 0;
    wait_idle();
    for (int i = 1; i < 4; i++) check("b2b_spacing", 64'(acc[i] - acc[i-1]), 64'd3);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
